// File: rtl/pipTypes.sv
// Pipeline-wide types and sizing shared by decode and the instruction queue.
// Any block that must agree on queue depth takes its default from here.
package pipTypes;

  localparam int IQ_DEPTHLOG2_DEFAULT = 3;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } dec_inst_t;

  typedef struct packed {
    logic [15:0] pc;
    dec_inst_t   inst;
  } iq_entry_t;

endpackage

// File: rtl/insn_queue.sv
// Dual-push, up-to-4-pop circular instruction queue; head window is read combinationally,
// pushes become visible one cycle later; decode stalls on full (fewer than 2 free slots).
module insn_queue
  import pipTypes::*;
#(
  parameter int IQ_DEPTHLOG2 = IQ_DEPTHLOG2_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ins_valid [2],
  input  iq_entry_t   ins_data  [2],
  output logic        full,
  input  logic        ext_enable,
  input  logic [1:0]  ext_consumed,
  output logic        ext_valid [4],
  output iq_entry_t   insns     [4],
  output logic        empty,
  input  logic        branch_flush
);

  localparam int DEPTH = 1 << IQ_DEPTHLOG2;
  localparam int PW    = IQ_DEPTHLOG2;
  localparam int CW    = IQ_DEPTHLOG2 + 1;

  iq_entry_t       storage [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [1:0]      n_wr;
  logic [CW-1:0]   n_rd;
  logic [CW:0]     req;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      insns[i]     = storage[rd_ptr + PW'(i)];
      ext_valid[i] = (count > CW'(i));
    end
    empty = (count == '0);
    full  = (count > CW'(DEPTH - 2));
  end

  // A full queue rejects the whole push pair; lane 1 alone is never a valid push.
  always_comb begin
    n_wr = 2'd0;
    if (!full && ins_valid[0]) begin
      n_wr = ins_valid[1] ? 2'd2 : 2'd1;
    end
  end

  // Over-requested pops saturate to what is actually held.
  always_comb begin
    req  = (CW+1)'(ext_consumed) + (CW+1)'(1);
    n_rd = '0;
    if (ext_enable) begin
      if (req > {1'b0, count}) begin
        n_rd = count;
      end else begin
        n_rd = req[CW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!branch_flush && n_wr != 2'd0) begin
      storage[wr_ptr] <= ins_data[0];
      if (n_wr == 2'd2) begin
        storage[wr_ptr + PW'(1)] <= ins_data[1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(n_rd);
      wr_ptr <= wr_ptr + PW'(n_wr);
      count  <= count + CW'(n_wr) - n_rd;
    end
  end

endmodule

// File: doc/insn_queue.md
INSN_QUEUE -- requirements
Module: insn_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTHLOG2, default 3, log2 of entry count (8 entries).
REQ-002 SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ins_valid[2]  input  1 each  decode push request per lane; lane 1 only with lane 0.
REQ-005 SHALL have port ins_data[2]  input  iq_entry_t each  entries pushed, lane 0 older.
REQ-006 SHALL have port full  output  1  fewer than 2 free entries.
REQ-007 SHALL have port ext_enable  input  1  issue consumes entries this cycle.
REQ-008 SHALL have port ext_consumed  input  2  entries consumed minus 1 (0..3 = 1..4).
REQ-009 SHALL have port ext_valid[4]  output  1 each  head window slot i holds a valid entry.
REQ-010 SHALL have port insns[4]  output  iq_entry_t each  head window, slot 0 oldest.
REQ-011 SHALL have port empty  output  1  no valid entries.
REQ-012 SHALL have port branch_flush  input  1  discard all contents.

Function
REQ-013 SHALL be a circular buffer with rd_ptr/wr_ptr (IQ_DEPTHLOG2 bits, wrap modulo depth) and count (IQ_DEPTHLOG2+1 bits).
REQ-014 SHALL drive insns[i] combinationally from storage[rd_ptr+i mod depth]; zero-latency read window.
REQ-015 SHALL drive ext_valid[i] = (count > i), empty = (count == 0), full = (count > depth-2), all from registered count.
REQ-016 SHALL compute pushes n_wr = ins_valid[0] + (ins_valid[0] & ins_valid[1]); ins_valid[1] without ins_valid[0] ignored.
REQ-017 SHALL ignore all pushes in a cycle where full is high (no partial write).
REQ-018 SHALL compute pops n_rd = ext_enable ? min(ext_consumed+1, count) : 0; overrequest saturates to count.
REQ-019 SHALL write lane 0 at wr_ptr and lane 1 at wr_ptr+1 on the clock edge; wr_ptr += n_wr.
REQ-020 SHALL advance rd_ptr += n_rd; count <= count + n_wr - n_rd; pops see pre-edge state only.
REQ-021 SHALL NOT forward an entry pushed this cycle to insns/ext_valid before the next cycle (1-cycle push-to-visible latency).
REQ-022 SHALL, on branch_flush, set rd_ptr, wr_ptr, count to 0 at the edge, discarding same-cycle pushes and pops.
REQ-023 SHALL never let count exceed depth; full-guard and saturation make overflow/underflow impossible.
REQ-024 SHALL hold state when no push, no pop, no flush.

Reset
REQ-025 SHALL asynchronously clear rd_ptr, wr_ptr, count on reset_n low; outputs then ext_valid all 0, empty 1, full 0.
REQ-026 SHALL NOT reset storage; insns is don't-care whenever its ext_valid is 0.
REQ-027 SHALL accept no push during reset; first push takes effect on first edge after reset_n deassertion.

Structure
REQ-028 SHALL use iq_entry_t and dec_inst_t from pipTypes; the IQ_DEPTHLOG2 default SHALL be a pipTypes constant shared with decode.
REQ-029 SHALL keep storage and pointer logic inline; no sub-module.

Verification
REQ-030 Reset then push A,B (both lanes) -> next cycle ext_valid=1100, insns[0]=A, insns[1]=B, empty=0.
REQ-031 Fill 6 entries, push 2 -> full=1 after; further push with full=1 -> count stays 8, contents unchanged.
REQ-032 Count=3, ext_enable=1, ext_consumed=3 -> count 0, empty=1 next cycle (saturation).
REQ-033 rd_ptr=6, count=4, pop 2 and push 2 same cycle -> count 4, insns[0] = entry at index 0 (wrap).
REQ-034 Count=5 with push and pop plus branch_flush -> next cycle count 0, empty=1, ext_valid=0000.
REQ-035 ins_valid=01 (lane 1 only) -> no write, count unchanged; reset_n low mid-fill -> empty=1 immediately.
